// File: rtl/memory_stage.sv
// memory_stage: waits for data-bus responses to issued loads/stores, aligns load
// data (including LWL/LWR merge), and hands one result per instruction to writeback.
`default_nettype none

`ifndef I_MAX
`define I_MEM_R 0
`define I_MEM_W 1
`define I_LB    2
`define I_LBU   3
`define I_LH    4
`define I_LHU   5
`define I_LW    6
`define I_LWL   7
`define I_LWR   8
`define I_WEX   9
`define I_MAX   10
`endif

module memory_stage (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic [31:0]       pc_i,
  input  logic [31:0]       inst_i,
  input  logic [`I_MAX-1:0] ctrl_i,
  input  logic [31:0]       result_i,
  input  logic [31:0]       eaddr_i,
  input  logic [31:0]       rdata2_i,
  input  logic [4:0]        waddr_i,
  output logic              ready_o,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata,
  input  logic              flush_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [31:0]       pc_o,
  output logic [31:0]       inst_o,
  output logic [31:0]       wdata_o,
  output logic [4:0]        waddr_o,
  output logic [4:0]        fwd_addr,
  output logic [31:0]       fwd_data,
  output logic              fwd_ok
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]  state, state_next;
  logic [1:0]  discard, discard_next;
  logic [31:0] hold_q;
  logic [31:0] aligned, shifted, load_data, wb_data;
  logic [4:0]  sh;
  logic        is_mem, is_load, live_resp, done, retire, capture, kill_inc, resp_dec;
  logic        unused_ok;

  assign unused_ok = ^eaddr_i[31:2];

  assign is_load   = ctrl_i[`I_MEM_R];
  assign is_mem    = ctrl_i[`I_MEM_R] | ctrl_i[`I_MEM_W];
  // Responses owed to killed instructions are swallowed until the counter drains.
  assign live_resp = data_data_ok && (discard == 2'd0);
  assign done      = !is_mem || live_resp || (state == S_HOLD);
  assign ready_o   = !valid_i || (done && ready_i);
  assign retire    = valid_i && done && ready_i && !flush_i;
  assign capture   = valid_i && is_mem && live_resp && !ready_i && !flush_i
                     && (state != S_HOLD);

  always_comb begin
    sh      = {eaddr_i[1:0], 3'b000};
    shifted = data_rdata >> sh;
    aligned = data_rdata;
    if (ctrl_i[`I_LB])
      aligned = {{24{shifted[7]}}, shifted[7:0]};
    else if (ctrl_i[`I_LBU])
      aligned = {24'h000000, shifted[7:0]};
    else if (ctrl_i[`I_LH])
      aligned = {{16{shifted[15]}}, shifted[15:0]};
    else if (ctrl_i[`I_LHU])
      aligned = {16'h0000, shifted[15:0]};
    else if (ctrl_i[`I_LWL])
      aligned = (data_rdata << (5'd24 - sh)) | (rdata2_i & (32'h00FFFFFF >> sh));
    else if (ctrl_i[`I_LWR])
      aligned = shifted | (rdata2_i & ~(32'hFFFFFFFF >> sh));
  end

  assign load_data = (state == S_HOLD) ? hold_q : aligned;
  assign wb_data   = is_load ? load_data : result_i;

  assign fwd_addr = valid_i ? waddr_i : 5'd0;
  assign fwd_data = wb_data;
  assign fwd_ok   = valid_i && done && (ctrl_i[`I_WEX] || is_load) && (waddr_i != 5'd0);

  always_comb begin
    state_next = state;
    if (flush_i) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (valid_i && is_mem)
                  state_next = live_resp ? (ready_i ? S_IDLE : S_HOLD) : S_WAIT;
        S_WAIT: if (live_resp)
                  state_next = ready_i ? S_IDLE : S_HOLD;
        S_HOLD: if (ready_i)
                  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // A kill only owes a discard if its response has not already been consumed.
  assign kill_inc = flush_i && valid_i && is_mem && !live_resp && (state != S_HOLD);
  assign resp_dec = data_data_ok && (discard != 2'd0);

  always_comb begin
    discard_next = discard;
    if (kill_inc && !resp_dec)
      discard_next = (discard == 2'd3) ? 2'd3 : discard + 2'd1;
    else if (resp_dec && !kill_inc)
      discard_next = discard - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      discard <= 2'd0;
    end else begin
      state   <= state_next;
      discard <= discard_next;
    end
  end

  always_ff @(posedge clk) begin
    if (capture)
      hold_q <= aligned;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_o <= 1'b0;
      pc_o    <= 32'd0;
      inst_o  <= 32'd0;
      wdata_o <= 32'd0;
      waddr_o <= 5'd0;
    end else if (retire) begin
      valid_o <= 1'b1;
      pc_o    <= pc_i;
      inst_o  <= inst_i;
      wdata_o <= wb_data;
      waddr_o <= waddr_i;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed stimulus with a queue-based scoreboard and a
// negedge monitor comparing every writeback handoff.
`default_nettype none

`ifndef I_MAX
`define I_MEM_R 0
`define I_MEM_W 1
`define I_LB    2
`define I_LBU   3
`define I_LH    4
`define I_LHU   5
`define I_LW    6
`define I_LWL   7
`define I_LWR   8
`define I_WEX   9
`define I_MAX   10
`endif

module tb_memory_stage;

  logic              clk = 1'b0;
  logic              reset;
  logic              valid_i;
  logic [31:0]       pc_i, inst_i, result_i, eaddr_i, rdata2_i;
  logic [`I_MAX-1:0] ctrl_i;
  logic [4:0]        waddr_i;
  logic              ready_o;
  logic              data_data_ok;
  logic [31:0]       data_rdata;
  logic              flush_i;
  logic              ready_i;
  logic              valid_o;
  logic [31:0]       pc_o, inst_o, wdata_o;
  logic [4:0]        waddr_o;
  logic [4:0]        fwd_addr;
  logic [31:0]       fwd_data;
  logic              fwd_ok;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] wdata;
    logic [4:0]  waddr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam int C_WEX = (1 << `I_WEX);
  localparam int C_LB  = (1 << `I_MEM_R) | (1 << `I_LB);
  localparam int C_LBU = (1 << `I_MEM_R) | (1 << `I_LBU);
  localparam int C_LW  = (1 << `I_MEM_R) | (1 << `I_LW);
  localparam int C_LWL = (1 << `I_MEM_R) | (1 << `I_LWL);
  localparam int C_LWR = (1 << `I_MEM_R) | (1 << `I_LWR);
  localparam int C_SW  = (1 << `I_MEM_W);

  memory_stage dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .pc_i(pc_i), .inst_i(inst_i),
    .ctrl_i(ctrl_i), .result_i(result_i), .eaddr_i(eaddr_i), .rdata2_i(rdata2_i),
    .waddr_i(waddr_i), .ready_o(ready_o), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .flush_i(flush_i), .ready_i(ready_i),
    .valid_o(valid_o), .pc_o(pc_o), .inst_o(inst_o), .wdata_o(wdata_o),
    .waddr_o(waddr_o), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .fwd_ok(fwd_ok)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endfunction

  // Monitor: every handoff to writeback must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && valid_o && ready_i) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_retire: pc_o 0x%08h wdata_o 0x%08h, none expected", pc_o, wdata_o);
        end else begin
          e = sb.pop_front();
          chk("wb_pc", pc_o, e.pc);
          chk("wb_inst", inst_o, e.inst);
          chk("wb_wdata", wdata_o, e.wdata);
          chk("wb_waddr", {27'd0, waddr_o}, {27'd0, e.waddr});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear();
    valid_i = 1'b0; pc_i = '0; inst_i = '0; ctrl_i = '0; result_i = '0;
    eaddr_i = '0; rdata2_i = '0; waddr_i = '0; data_data_ok = 1'b0;
    data_rdata = '0; flush_i = 1'b0;
  endtask

  task automatic issue(input logic [31:0] pc, input int ctrl, input logic [31:0] res,
                       input logic [31:0] ea, input logic [31:0] rt, input logic [4:0] wa);
    int c;
    c = ctrl;
    valid_i = 1'b1; pc_i = pc; inst_i = pc ^ 32'hA5A5_0000; ctrl_i = c[`I_MAX-1:0];
    result_i = res; eaddr_i = ea; rdata2_i = rt; waddr_i = wa;
  endtask

  task automatic resp(input logic [31:0] d);
    data_data_ok = 1'b1; data_rdata = d;
  endtask

  task automatic expect_wb(input logic [31:0] pc, input logic [31:0] wd, input logic [4:0] wa);
    exp_t e;
    e.pc = pc; e.inst = pc ^ 32'hA5A5_0000; e.wdata = wd; e.waddr = wa;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      clear();
      cyc();
    end
  endtask

  initial begin
    clear();
    ready_i = 1'b1;
    reset = 1'b1;
    cyc(); cyc();
    settle();
    chk("reset_valid_o", {31'd0, valid_o}, 32'd0);
    chk("reset_wdata_o", wdata_o, 32'd0);
    chk("reset_pc_o", pc_o, 32'd0);
    chk("reset_waddr_o", {27'd0, waddr_o}, 32'd0);
    chk("reset_ready_o", {31'd0, ready_o}, 32'd1);
    reset = 1'b0;
    cyc();

    // ADDU: zero latency, forwarded combinationally
    issue(32'h100, C_WEX, 32'd7, 32'd0, 32'd0, 5'd5);
    settle();
    chk("addu_fwd_ok", {31'd0, fwd_ok}, 32'd1);
    chk("addu_fwd_addr", {27'd0, fwd_addr}, 32'd5);
    chk("addu_fwd_data", fwd_data, 32'd7);
    chk("addu_ready_o", {31'd0, ready_o}, 32'd1);
    expect_wb(32'h100, 32'd7, 5'd5);
    cyc();
    clear();
    settle();
    chk("addu_valid_next_edge", {31'd0, valid_o}, 32'd1);
    chk("idle_fwd_addr", {27'd0, fwd_addr}, 32'd0);
    cyc();

    // LB / LBU, offset 3, response in the issue cycle
    issue(32'h200, C_LB, 32'd0, 32'h1003, 32'd0, 5'd3);
    resp(32'h80FF1234);
    settle();
    chk("lb_fwd_ok", {31'd0, fwd_ok}, 32'd1);
    chk("lb_fwd_data", fwd_data, 32'hFFFFFF80);
    expect_wb(32'h200, 32'hFFFFFF80, 5'd3);
    cyc();
    issue(32'h204, C_LBU, 32'd0, 32'h1003, 32'd0, 5'd4);
    resp(32'h80FF1234);
    expect_wb(32'h204, 32'h00000080, 5'd4);
    cyc();

    // LWL / LWR merge with old rt
    issue(32'h300, C_LWL, 32'd0, 32'h2001, 32'h11223344, 5'd6);
    resp(32'hAABBCCDD);
    settle();
    chk("lwl_fwd_data", fwd_data, 32'hCCDD3344);
    expect_wb(32'h300, 32'hCCDD3344, 5'd6);
    cyc();
    issue(32'h304, C_LWR, 32'd0, 32'h2001, 32'h11223344, 5'd7);
    resp(32'hAABBCCDD);
    expect_wb(32'h304, 32'h11AABBCC, 5'd7);
    cyc();
    idle(2);

    // LW: WAIT for two cycles, response with ready_i=0, HOLD, then release
    issue(32'h400, C_LW, 32'd0, 32'h3000, 32'd0, 5'd8);
    settle();
    chk("lw_wait_ready_o", {31'd0, ready_o}, 32'd0);
    chk("lw_wait_fwd_ok", {31'd0, fwd_ok}, 32'd0);
    cyc();
    settle();
    chk("lw_wait2_ready_o", {31'd0, ready_o}, 32'd0);
    ready_i = 1'b0;
    resp(32'hCAFEF00D);
    cyc();
    data_data_ok = 1'b0; data_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("hold_ready_o", {31'd0, ready_o}, 32'd0);
      chk("hold_valid_o", {31'd0, valid_o}, 32'd0);
      cyc();
    end
    ready_i = 1'b1;
    settle();
    chk("hold_release_ready_o", {31'd0, ready_o}, 32'd1);
    chk("hold_fwd_data", fwd_data, 32'hCAFEF00D);
    expect_wb(32'h400, 32'hCAFEF00D, 5'd8);
    cyc();
    idle(2);

    // Flush in WAIT: first response afterwards is discarded
    issue(32'h600, C_LW, 32'd0, 32'h4000, 32'd0, 5'd2);
    cyc();
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    issue(32'h604, C_LW, 32'd0, 32'h4004, 32'd0, 5'd9);
    resp(32'hDEAD0000);
    settle();
    chk("discard_ready_o", {31'd0, ready_o}, 32'd0);
    chk("discard_fwd_ok", {31'd0, fwd_ok}, 32'd0);
    cyc();
    resp(32'h12345678);
    settle();
    chk("after_discard_fwd_data", fwd_data, 32'h12345678);
    expect_wb(32'h604, 32'h12345678, 5'd9);
    cyc();
    idle(1);

    // Response and flush together: consumed, no discard owed
    issue(32'h680, C_LW, 32'd0, 32'h4100, 32'd0, 5'd10);
    cyc();
    resp(32'h0F0F0F0F);
    flush_i = 1'b1;
    cyc();
    clear();
    issue(32'h684, C_LW, 32'd0, 32'h4104, 32'd0, 5'd11);
    resp(32'h55AA55AA);
    settle();
    chk("flush_resp_no_discard", {31'd0, ready_o}, 32'd1);
    expect_wb(32'h684, 32'h55AA55AA, 5'd11);
    cyc();
    idle(1);

    // Store: waits for response, never forwarded
    issue(32'h700, C_SW, 32'h00000ABC, 32'h5000, 32'd0, 5'd0);
    settle();
    chk("store_wait_ready_o", {31'd0, ready_o}, 32'd0);
    chk("store_wait_fwd_ok", {31'd0, fwd_ok}, 32'd0);
    cyc();
    resp(32'h0);
    settle();
    chk("store_resp_fwd_ok", {31'd0, fwd_ok}, 32'd0);
    expect_wb(32'h700, 32'h00000ABC, 5'd0);
    cyc();
    idle(1);

    // Reset in WAIT with a pending discard; next load must complete normally
    issue(32'h800, C_LW, 32'd0, 32'h6000, 32'd0, 5'd12);
    cyc();
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    issue(32'h804, C_LW, 32'd0, 32'h6004, 32'd0, 5'd13);
    cyc();
    clear();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    settle();
    chk("reset_wait_valid_o", {31'd0, valid_o}, 32'd0);
    issue(32'h900, C_LW, 32'd0, 32'h7000, 32'd0, 5'd14);
    resp(32'h0BADBEEF);
    settle();
    chk("post_reset_ready_o", {31'd0, ready_o}, 32'd1);
    chk("post_reset_fwd_data", fwd_data, 32'h0BADBEEF);
    expect_wb(32'h900, 32'h0BADBEEF, 5'd14);
    cyc();
    idle(3);

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/memory_stage.md
# memory_stage

Pipeline stage directly downstream of the execute stage. It takes the registered execute-stage outputs and waits for the data-bus response to loads and stores that execute already issued. It aligns and extends load data, including the LWL/LWR merge with the old rt value. It then hands a single writeback result to the writeback stage and drives the forwarding port for this stage.

## Interface
Parameters: none. The control-field layout comes from `common.vh` (`I_MAX`, `I_MEM_R`, `I_MEM_W`, `I_LB`, `I_LBU`, `I_LH`, `I_LHU`, `I_LW`, `I_LWL`, `I_LWR`, `I_WEX`).
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- valid_i  in  1  execute-stage result is valid
- pc_i  in  32  instruction PC
- inst_i  in  32  instruction word
- ctrl_i  in  `I_MAX`  decoded control bits
- result_i  in  32  execute result (ALU, LUI, link, MFHI/LO, MFC0)
- eaddr_i  in  32  effective address; bits [1:0] select the byte lane
- rdata2_i  in  32  old rt value, used for the LWL/LWR merge
- waddr_i  in  5  destination register; 0 means no write
- ready_o  out  1  this stage accepts a new instruction at the next edge
- data_data_ok  in  1  data-bus response strobe; responses return in issue order
- data_rdata  in  32  response data, valid when data_data_ok=1
- flush_i  in  1  kill the instruction in this stage (exception or ERET commit)
- ready_i  in  1  writeback stage accepts
- valid_o, pc_o, inst_o  out  1/32/32  registered outputs to writeback
- wdata_o  out  32  registered writeback data
- waddr_o  out  5  registered destination register
- fwd_addr  out  5  destination of the in-stage instruction; 0 when valid_i=0
- fwd_data  out  32  final value of the in-stage instruction
- fwd_ok  out  1  fwd_data is final this cycle

## Operation
- Memory op: ctrl_i[`I_MEM_R`] or ctrl_i[`I_MEM_W`] is set. Stores also wait for data_data_ok. Stores never write a register.
- State machine:
  - IDLE → WAIT when a valid memory op is present, no live response arrives, and flush_i=0.
  - WAIT → HOLD when a live response arrives and ready_i=0. The aligned data is captured into a 32-bit hold register.
  - WAIT → IDLE when a live response arrives and ready_i=1.
  - HOLD → IDLE when ready_i=1.
  - flush_i forces the state to IDLE.
- done:
  - Non-memory op: done=1.
  - Memory op: done is live response, or state==HOLD.
- ready_o = !valid_i || (done && ready_i).
- Retire condition: valid_i && done && ready_i && !flush_i. On the next edge, valid_o=1 and pc_o/inst_o/waddr_o/wdata_o are loaded. Otherwise valid_o=0 while ready_i=1, and the outputs hold while ready_i=0.
- Load alignment (off = eaddr_i[1:0], m = response word):
  - LB/LBU: byte m[8·off+7 : 8·off], sign- or zero-extended.
  - LH/LHU: halfword m[8·off+15 : 8·off], with off∈{0,2}.
  - LW: m.
  - LWL: (m << 8·(3−off)) | (rdata2_i & (32'h00FFFFFF >> 8·off)).
  - LWR: (m >> 8·off) | (rdata2_i & ~(32'hFFFFFFFF >> 8·off)).
- wdata source: aligned load data for loads; result_i otherwise.
- Discard counter (2 bits, saturating at 3):
  - Increments when flush_i kills a valid memory op whose response has not arrived. This also covers a memory op in IDLE whose response is absent this cycle.
  - A response is live only while the counter is 0.
  - While the counter is nonzero, each data_data_ok decrements it and the response is ignored.
- Forwarding:
  - fwd_addr = valid_i ? waddr_i : 0.
  - fwd_data = wdata source.
  - fwd_ok = valid_i && done && ctrl_i[`I_WEX`]-or-load && waddr_i!=0.

## Timing
- Reset values: state=IDLE, discard=0, valid_o=0, all other registered outputs 0.
- Non-memory op: zero added latency. valid_o appears at the edge after valid_i when ready_i=1.
- Load with a response in the same cycle as valid_i: retires that cycle.
- Load with a response N cycles later: N cycles in WAIT, and ready_o=0 throughout.
- Response and flush_i in the same cycle: the response is consumed by the killed instruction. The counter does not increment and nothing retires.
- Response with discard=1 and a new load waiting: the response is dropped and the counter goes 0. The next response is delivered.
- Discard at 3 with another kill pending: ready_o=0 until a decrement.
- Reset mid-WAIT or mid-HOLD: back to IDLE, discard=0. The hold register content is don't-care.

## Test plan
- LB, eaddr=…3, m=32'h80FF1234, ready_i=1 → wdata_o=32'hFFFFFF80. With LBU → 32'h00000080. fwd_ok=1 in the response cycle.
- LWL off=1, m=32'hAABBCCDD, rt=32'h11223344 → 32'hCCDD3344. LWR off=1, same m and rt → 32'h11AABBCC.
- LW, response with ready_i=0 for 3 cycles → HOLD:
  - ready_o=0 and valid_o=0 throughout.
  - ready_i rises → valid_o=1 with the captured word at the next edge.
- Load in WAIT, flush_i pulse; next load issued; two responses 0xDEAD0000 then 0x12345678 → first discarded, wdata_o=0x12345678.
- ADDU with result 7, waddr 5 → valid_o=1 at the next edge, wdata_o=7, fwd_ok=1 combinationally. Store with a later response → valid_o=1 after the response, nothing forwarded.
- reset asserted during WAIT → next cycle valid_o=0, state IDLE. A subsequent load completes normally.
